// File: rtl/tqvp_wdt_checkin_ctrl.sv
// Watchdog check-in controller: collects per-task check-ins and taps an external
// watchdog over its TinyQV bus slave once every task in TASK_MASK has reported.
module tqvp_wdt_checkin_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [5:0]  wdt_address,
    output logic [31:0] wdt_data,
    output logic [1:0]  wdt_write_n,
    input  logic        wdt_timeout,
    output logic        user_interrupt
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_TAP     = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;
    localparam logic [2:0] S_DISARM  = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic        arm_q, arm_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] holdoff_q, holdoff_d;
    logic [31:0] reload_q, reload_d;
    logic [7:0]  seen_q, seen_d;
    logic [7:0]  missed_q, missed_d;
    logic        cfg_err_q, cfg_err_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  beat_addr_q, beat_addr_d;
    logic [31:0] beat_data_q, beat_data_d;
    logic        beat_vld_q, beat_vld_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic        irq_q;

    logic        wr_en, rd_en;
    logic [31:0] wdata;
    logic        wr_ctrl, wr_checkin;
    logic [7:0]  checkin_bits;
    logic        disarm_req;

    always_comb begin
        wr_en = (data_write_n != 2'b11);
        rd_en = (data_read_n != 2'b11);
        case (data_write_n)
            2'b00:   wdata = {24'd0, data_in[7:0]};
            2'b01:   wdata = {16'd0, data_in[15:0]};
            default: wdata = data_in;
        endcase
        wr_ctrl    = wr_en && (address == 6'h00);
        wr_checkin = wr_en && (address == 6'h08);
        checkin_bits = (wr_checkin && state_q != S_IDLE && state_q != S_FAULT)
                       ? (wdata[7:0] & mask_q) : 8'h00;
        disarm_req = wr_ctrl && !wdata[0] && state_q != S_IDLE && state_q != S_DISARM;

        arm_d     = wr_ctrl ? wdata[0] : arm_q;
        mask_d    = (wr_en && address == 6'h04) ? wdata[7:0]  : mask_q;
        holdoff_d = (wr_en && address == 6'h0C) ? wdata[15:0] : holdoff_q;
        reload_d  = (wr_en && address == 6'h10) ? wdata       : reload_q;

        state_d   = state_q;
        seen_d    = seen_q | checkin_bits;
        cnt_d     = cnt_q;
        missed_d  = missed_q;
        fault_d   = fault_q;
        cfg_err_d = wr_ctrl ? 1'b0 : cfg_err_q;

        case (state_q)
            S_IDLE: begin
                if (wr_ctrl && wdata[0]) begin
                    if (reload_q != 32'd0) state_d = S_LOAD;
                    else                   cfg_err_d = 1'b1;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_COLLECT;
            S_COLLECT: begin
                if (wdt_timeout) begin
                    state_d  = S_FAULT;
                    missed_d = mask_q & ~seen_q;
                    fault_d  = 1'b1;
                end else if (mask_q != 8'h00 && (seen_q & mask_q) == mask_q) begin
                    state_d = S_TAP;
                end
            end
            S_TAP: begin
                // Check-ins landing on the tap cycle belong to the next round.
                seen_d  = checkin_bits;
                cnt_d   = holdoff_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (wdt_timeout) begin
                    state_d  = S_FAULT;
                    missed_d = mask_q & ~seen_q;
                    fault_d  = 1'b1;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_COLLECT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DISARM: begin
                seen_d   = 8'h00;
                fault_d  = 1'b0;
                missed_d = 8'h00;
                state_d  = S_IDLE;
            end
            default: ;
        endcase

        // Beats are tied to state; a beat already on the bus this cycle completes first.
        if (disarm_req) state_d = S_DISARM;

        beat_vld_d  = 1'b1;
        beat_addr_d = 6'h00;
        beat_data_d = 32'd0;
        case (state_d)
            S_LOAD:   begin beat_addr_d = 6'h08; beat_data_d = reload_q; end
            S_START:  beat_addr_d = 6'h04;
            S_TAP:    begin beat_addr_d = 6'h0C; beat_data_d = 32'h0000_ABCD; end
            S_DISARM: ;
            default:  beat_vld_d = 1'b0;
        endcase

        rvld_d  = rd_en;
        rdata_d = 32'd0;
        if (rd_en) begin
            case (address)
                6'h00: rdata_d = {31'd0, arm_q};
                6'h04: rdata_d = {24'd0, mask_q};
                6'h0C: rdata_d = {16'd0, holdoff_q};
                6'h10: rdata_d = reload_q;
                6'h14: rdata_d = {16'd0, missed_q, cfg_err_q, fault_q, state_q, 3'd0};
                6'h18: rdata_d = {24'd0, seen_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            mask_q      <= 8'h00;
            holdoff_q   <= 16'd0;
            reload_q    <= 32'd0;
            seen_q      <= 8'h00;
            missed_q    <= 8'h00;
            cfg_err_q   <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= 16'd0;
            beat_vld_q  <= 1'b0;
            beat_addr_q <= 6'h00;
            beat_data_q <= 32'd0;
            rvld_q      <= 1'b0;
            rdata_q     <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            mask_q      <= mask_d;
            holdoff_q   <= holdoff_d;
            reload_q    <= reload_d;
            seen_q      <= seen_d;
            missed_q    <= missed_d;
            cfg_err_q   <= cfg_err_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            beat_vld_q  <= beat_vld_d;
            beat_addr_q <= beat_addr_d;
            beat_data_q <= beat_data_d;
            rvld_q      <= rvld_d;
            rdata_q     <= rdata_d;
            irq_q       <= fault_d;
        end
    end

    assign wdt_write_n    = beat_vld_q ? 2'b10 : 2'b11;
    assign wdt_address    = beat_addr_q;
    assign wdt_data       = beat_data_q;
    assign data_out       = rdata_q;
    assign data_ready     = rvld_q;
    assign user_interrupt = irq_q;
endmodule
